rob_multiport: RTL and testbench
================================

# rob_multiport

Parametrised reorder buffer that replaces the single-writeback ROB in the execute stage: configurable depth and number of writeback ports, in-order commit to RegFile and LSB, and branch-mispredict recovery. Entries are allocated by the Decoder, completed by RS/LSB/branch units over `WB_PORTS` writeback ports, and retired one per cycle from the head. A mispredicted branch at the head empties the buffer and emits a registered redirect pulse to fetch.

## Interface
- `ROB_SIZE_BIT`, default `ROB_WIDTH_BIT`: log2 of the entry count; depth `D = 1 << ROB_SIZE_BIT`.
- `WB_PORTS`, default 2: number of writeback ports (1..4).
- `clk_in  in  1`: clock; everything is updated on posedge.
- `rst_in  in  1`: asynchronous, active-low reset.
- `rdy_in  in  1`: when low, all state is held, `commit_valid=0`, and `alloc_ready=0`.
- `alloc_valid  in  1`, `alloc_ready  out  1`: allocation handshake; an entry is allocated when both are high.
- `alloc_type  in  2`: entry type; 0 Rd, 1 St, 2 Br, 3 Other.
- `alloc_rd  in  5`, `alloc_done  in  1`, `alloc_val  in  32`: destination register, already-complete flag, and initial value.
- `alloc_pc  in  32`, `alloc_pred_pc  in  32`: instruction address and predicted next PC (Br only).
- `alloc_id  out  ROB_SIZE_BIT`: current tail, i.e. the id given to the allocating instruction.
- `wb_valid  in  WB_PORTS`, `wb_id  in  WB_PORTS*ROB_SIZE_BIT`, `wb_val  in  WB_PORTS*32`: flattened writeback ports; port k occupies slice k. For Br entries `wb_val` is the actual next PC.
- `commit_valid  out  1`, `commit_type  out  2`, `commit_rd  out  5`, `commit_val  out  32`, `commit_id  out  ROB_SIZE_BIT`: head retirement, combinational.
- `st_commit_ready  in  1`: LSB accepts a store commit this cycle.
- `q1_id  in  ROB_SIZE_BIT`, `q1_ready  out  1`, `q1_val  out  32`: operand query 1. `q2_*` is identical.
- `flush_out  out  1` (reg), `flush_pc  out  32` (reg): mispredict redirect.
- `full  out  1`, `empty  out  1`, `count  out  ROB_SIZE_BIT+1`.

## Operation
- Per-entry state: busy, done, type, rd, val, pc, pred_pc. Pointers `head` and `tail` wrap modulo D. `count` is a separate register.
- `alloc_ready = rdy_in && !flush_out && count < D`. On allocation, write all fields at `tail`, set busy, set done to `alloc_done`, and advance `tail`.
- Writeback: for each port k with `wb_valid[k]` and a busy target entry, set done=1 and val=`wb_val[k]`. A writeback to a non-busy entry is ignored.
- Two ports hitting the same id in one cycle: the higher index wins.
- A writeback is ignored while `flush_out=1`.
- Commit condition: `rdy_in && busy[head] && done[head] && (type!=St || st_commit_ready)`. `commit_valid` mirrors this condition; the head advances and busy clears on the same edge.
- Mispredict: head is Br, it commits, and `val != pred_pc`. On that edge:
  - all busy/done bits clear, and `head=tail=count=0`;
  - `flush_out<=1` and `flush_pc<=val`;
  - any allocation presented in the same cycle is discarded.
- `flush_out` stays high for exactly one cycle.
- Query outputs: `qN_ready = done[qN_id]`, `qN_val = val[qN_id]`.
- `count` next value = `count + alloc − commit`. A simultaneous alloc and commit leaves `count` unchanged. `full = (count==D)`, `empty = (count==0)`.

## Timing
- Reset values: `flush_out=0`, `flush_pc=0`, `count=0`, `empty=1`, `full=0`, `alloc_id=0`, `commit_valid=0`, `qN_ready=0`, `qN_val=0`.
- Reset asserted mid-operation clears all entries immediately.
- Allocate-to-commit latency: at least 1 cycle. An entry allocated with `alloc_done=1` at edge N can commit in cycle N+1.
- Writeback at edge N: the entry is visible to queries and commit in cycle N+1.
- Mispredict commit at edge N: `flush_out` is high during cycle N+1, and allocation can resume at edge N+2.
- Store stall: while `st_commit_ready=0`, the head holds and `commit_valid=0`. Allocation may continue until `full`.

## Configuration
- `ROB_WB_BYPASS_EN` defined: queries also match the current-cycle `wb_*` ports (highest matching index wins). A query then returns ready with the writeback value in the same cycle the writeback is presented.
- Undefined: queries see stored state only, so a writeback becomes visible one cycle later.

## Structure
- `const.v` holds `ROB_WIDTH_BIT`, `ROB_TYPE` and the type encodings `ROB_T_RD`, `ROB_T_ST`, `ROB_T_BR`, `ROB_T_OTHER`.
- Sub-module `rob_operand_lookup`: one instance per query port; it contains the stored read and the optional bypass mux.

## Test plan
- Reset, then allocate 3 Rd entries with `alloc_done=0`:
  - `count=3`, `empty=0`, `alloc_id` sequence 0,1,2.
  - Write back id1 with 0x55: no commit, because head is id0.
- Continuing from the previous test, write back id0 with 0x11:
  - next cycle `commit_valid=1`, `commit_id=0`, `commit_val=0x11`;
  - the cycle after, `commit_id=1`, `commit_val=0x55`.
- Fill all D entries: `full=1` and `alloc_ready=0`. Commit one entry while `alloc_valid` is held: exactly one allocation at wrapped `tail=0`.
- Br entry with `pred_pc=0x100` and writeback 0x200 at head:
  - next cycle `flush_out=1`, `flush_pc=0x200`, `count=0`;
  - `alloc_ready=0` during that cycle, and an allocation attempted there is dropped.
- St at head with `st_commit_ready=0` for 4 cycles: `commit_valid` stays 0. When `st_commit_ready` rises, the store commits in the same cycle.
- Same-cycle writeback to id2 on ports 0 and 1 (0xA and 0xB): stored val=0xB. With `ROB_WB_BYPASS_EN`, a `q1_id=2` query in that cycle returns ready with 0xB.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// Reorder-buffer shared definitions: default depth exponent, entry-type encoding, static entry fields.
// Latency: none (declarations only).
// Backpressure: n/a. ROB_WB_BYPASS_EN, when defined, enables writeback bypass in rob_operand_lookup.
package rob_multiport_pkg;

    localparam int ROB_WIDTH_BIT = 4;
    localparam int ROB_TYPE      = 2;

    typedef enum logic [ROB_TYPE-1:0] {
        ROB_T_RD    = 2'd0,
        ROB_T_ST    = 2'd1,
        ROB_T_BR    = 2'd2,
        ROB_T_OTHER = 2'd3
    } rob_type_e;

    // Fields fixed at allocation; val/busy/done live separately because writeback touches them.
    typedef struct packed {
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pred_pc;
    } rob_meta_t;

endpackage

// File: rtl/rob_operand_lookup.sv
// Operand query for one port: stored done/val of the queried entry, optional same-cycle writeback bypass.
// Latency: combinational.
// Backpressure: none. ROB_WB_BYPASS_EN selects the bypass path; default reads stored state only.
module rob_operand_lookup
    import rob_multiport_pkg::*;
#(
    parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT,
    parameter int WB_PORTS     = 2
) (
    input  logic [ROB_SIZE_BIT-1:0]          q_id,
    input  logic [(1<<ROB_SIZE_BIT)-1:0]     done_vec,
    input  logic [31:0]                      val_arr [1<<ROB_SIZE_BIT],
    input  logic [WB_PORTS-1:0]              wb_hit,
    input  logic [WB_PORTS*ROB_SIZE_BIT-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]           wb_val,
    output logic                             q_ready,
    output logic [31:0]                      q_val
);

`ifdef ROB_WB_BYPASS_EN
    // Ascending scan so the highest-index matching port overrides.
    always_comb begin
        q_ready = done_vec[q_id];
        q_val   = val_arr[q_id];
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_hit[k] && (wb_id[k*ROB_SIZE_BIT +: ROB_SIZE_BIT] == q_id)) begin
                q_ready = 1'b1;
                q_val   = wb_val[k*32 +: 32];
            end
        end
    end
`else
    assign q_ready = done_vec[q_id];
    assign q_val   = val_arr[q_id];

    logic unused_wb;
    assign unused_wb = ^{wb_hit, wb_id, wb_val};
`endif

endmodule

// File: rtl/rob_multiport.sv
// Multi-writeback reorder buffer: in-order allocate, out-of-order complete, in-order retire with mispredict flush.
// Latency: alloc/writeback visible next cycle; commit outputs combinational from head; flush pulse registered.
// Backpressure: alloc_ready drops when full, flushing or !rdy_in; store commit waits on st_commit_ready. Option: ROB_WB_BYPASS_EN.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int ROB_SIZE_BIT = ROB_WIDTH_BIT,
    parameter int WB_PORTS     = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             rdy_in,
    input  logic                             alloc_valid,
    output logic                             alloc_ready,
    input  logic [1:0]                       alloc_type,
    input  logic [4:0]                       alloc_rd,
    input  logic                             alloc_done,
    input  logic [31:0]                      alloc_val,
    input  logic [31:0]                      alloc_pc,
    input  logic [31:0]                      alloc_pred_pc,
    output logic [ROB_SIZE_BIT-1:0]          alloc_id,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS*ROB_SIZE_BIT-1:0] wb_id,
    input  logic [WB_PORTS*32-1:0]           wb_val,
    output logic                             commit_valid,
    output logic [1:0]                       commit_type,
    output logic [4:0]                       commit_rd,
    output logic [31:0]                      commit_val,
    output logic [ROB_SIZE_BIT-1:0]          commit_id,
    input  logic                             st_commit_ready,
    input  logic [ROB_SIZE_BIT-1:0]          q1_id,
    output logic                             q1_ready,
    output logic [31:0]                      q1_val,
    input  logic [ROB_SIZE_BIT-1:0]          q2_id,
    output logic                             q2_ready,
    output logic [31:0]                      q2_val,
    output logic                             flush_out,
    output logic [31:0]                      flush_pc,
    output logic                             full,
    output logic                             empty,
    output logic [ROB_SIZE_BIT:0]            count
);

    localparam int                D     = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0] DEPTH = (ROB_SIZE_BIT+1)'(D);

    logic [D-1:0]            busy;
    logic [D-1:0]            done;
    rob_meta_t               meta [D];
    logic [31:0]             val  [D];
    logic [ROB_SIZE_BIT-1:0] head;
    logic [ROB_SIZE_BIT-1:0] tail;

    logic [ROB_SIZE_BIT-1:0] wb_id_a  [WB_PORTS];
    logic [31:0]             wb_val_a [WB_PORTS];
    logic [WB_PORTS-1:0]     wb_hit;
    rob_meta_t               head_meta;
    logic                    alloc_fire;
    logic                    mispredict;

    // Writebacks only land on live entries and never during the flush cycle.
    always_comb begin
        for (int k = 0; k < WB_PORTS; k++) begin
            wb_id_a[k]  = wb_id[k*ROB_SIZE_BIT +: ROB_SIZE_BIT];
            wb_val_a[k] = wb_val[k*32 +: 32];
            wb_hit[k]   = rdy_in && !flush_out && wb_valid[k] && busy[wb_id_a[k]];
        end
    end

    assign head_meta    = meta[head];
    assign alloc_ready  = rdy_in && !flush_out && (count < DEPTH);
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_valid = rdy_in && busy[head] && done[head]
                          && ((head_meta.typ != ROB_T_ST) || st_commit_ready);
    assign mispredict   = commit_valid && (head_meta.typ == ROB_T_BR)
                          && (val[head] != head_meta.pred_pc);

    assign commit_type = head_meta.typ;
    assign commit_rd   = head_meta.rd;
    assign commit_val  = val[head];
    assign commit_id   = head;
    assign alloc_id    = tail;
    assign full        = (count == DEPTH);
    assign empty       = (count == '0);

    logic unused_pc;
    assign unused_pc = ^head_meta.pc;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy      <= '0;
            done      <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            flush_out <= 1'b0;
            flush_pc  <= '0;
            for (int i = 0; i < D; i++) begin
                meta[i] <= '0;
                val[i]  <= '0;
            end
        end else begin
            flush_out <= 1'b0;
            if (mispredict) begin
                // Same-cycle allocation is dropped along with everything younger.
                busy      <= '0;
                done      <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                flush_out <= 1'b1;
                flush_pc  <= val[head];
            end else if (rdy_in) begin
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (wb_hit[k]) begin
                        done[wb_id_a[k]] <= 1'b1;
                        val[wb_id_a[k]]  <= wb_val_a[k];
                    end
                end
                if (commit_valid) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                if (alloc_fire) begin
                    busy[tail] <= 1'b1;
                    done[tail] <= alloc_done;
                    val[tail]  <= alloc_val;
                    meta[tail] <= '{typ: rob_type_e'(alloc_type), rd: alloc_rd,
                                    pc: alloc_pc, pred_pc: alloc_pred_pc};
                    tail       <= tail + 1'b1;
                end
                count <= count + (ROB_SIZE_BIT+1)'(alloc_fire) - (ROB_SIZE_BIT+1)'(commit_valid);
            end
        end
    end

    rob_operand_lookup #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .WB_PORTS(WB_PORTS)) u_q1 (
        .q_id(q1_id), .done_vec(done), .val_arr(val), .wb_hit(wb_hit),
        .wb_id(wb_id), .wb_val(wb_val), .q_ready(q1_ready), .q_val(q1_val)
    );

    rob_operand_lookup #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .WB_PORTS(WB_PORTS)) u_q2 (
        .q_id(q2_id), .done_vec(done), .val_arr(val), .wb_hit(wb_hit),
        .wb_id(wb_id), .wb_val(wb_val), .q_ready(q2_ready), .q_val(q2_val)
    );

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed scenarios plus randomized traffic against a queue-style reference model.
// Outputs are checked each cycle on the falling edge; inputs change 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_rob_multiport;
    import rob_multiport_pkg::*;

    localparam int SB = 3;
    localparam int WP = 2;
    localparam int D  = 1 << SB;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              rdy_in = 1'b0;
    logic              alloc_valid, alloc_ready, alloc_done;
    logic [1:0]        alloc_type;
    logic [4:0]        alloc_rd;
    logic [31:0]       alloc_val, alloc_pc, alloc_pred_pc;
    logic [SB-1:0]     alloc_id;
    logic [WP-1:0]     wb_valid;
    logic [WP*SB-1:0]  wb_id;
    logic [WP*32-1:0]  wb_val;
    logic              commit_valid;
    logic [1:0]        commit_type;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_val;
    logic [SB-1:0]     commit_id;
    logic              st_commit_ready;
    logic [SB-1:0]     q1_id, q2_id;
    logic              q1_ready, q2_ready;
    logic [31:0]       q1_val, q2_val;
    logic              flush_out;
    logic [31:0]       flush_pc;
    logic              full, empty;
    logic [SB:0]       count;

    rob_multiport #(.ROB_SIZE_BIT(SB), .WB_PORTS(WP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
        .alloc_rd(alloc_rd), .alloc_done(alloc_done), .alloc_val(alloc_val),
        .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc), .alloc_id(alloc_id),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .commit_valid(commit_valid), .commit_type(commit_type), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_id(commit_id), .st_commit_ready(st_commit_ready),
        .q1_id(q1_id), .q1_ready(q1_ready), .q1_val(q1_val),
        .q2_id(q2_id), .q2_ready(q2_ready), .q2_val(q2_val),
        .flush_out(flush_out), .flush_pc(flush_pc),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: a circular window of n live entries starting at m_head.
    bit          m_busy [D];
    bit          m_done [D];
    logic [1:0]  m_typ  [D];
    logic [4:0]  m_rd   [D];
    logic [31:0] m_val  [D];
    logic [31:0] m_pred [D];
    int          m_head, m_n;
    bit          m_flush;
    logic [31:0] m_fpc;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_typ[i] = 2'd0;
            m_rd[i] = 5'd0; m_val[i] = 32'd0; m_pred[i] = 32'd0;
        end
        m_head = 0; m_n = 0; m_flush = 0; m_fpc = 32'd0;
    endtask

    task automatic model_query(input int id, output logic r, output logic [31:0] v);
        r = m_done[id];
        v = m_val[id];
`ifdef ROB_WB_BYPASS_EN
        for (int k = 0; k < WP; k++) begin
            int wid;
            wid = int'(wb_id[k*SB +: SB]);
            if (rdy_in && !m_flush && wb_valid[k] && m_busy[wid] && wid == id) begin
                r = 1'b1;
                v = wb_val[k*32 +: 32];
            end
        end
`endif
    endtask

    task automatic set_idle();
        alloc_valid = 0; alloc_type = 2'd0; alloc_rd = 5'd0; alloc_done = 0;
        alloc_val = 32'd0; alloc_pc = 32'd0; alloc_pred_pc = 32'd0;
        wb_valid = '0; wb_id = '0; wb_val = '0;
        st_commit_ready = 1; q1_id = '0; q2_id = '0;
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic dn,
                             input logic [31:0] v, input logic [31:0] pred);
        alloc_valid = 1; alloc_type = t; alloc_rd = rd; alloc_done = dn;
        alloc_val = v; alloc_pc = 32'h1000; alloc_pred_pc = pred;
    endtask

    task automatic set_wb(input int k, input int id, input logic [31:0] v);
        wb_valid[k] = 1'b1;
        wb_id[k*SB +: SB] = SB'(id);
        wb_val[k*32 +: 32] = v;
    endtask

    // Check all outputs against the model, then advance the model across the next rising edge.
    task automatic cycle();
        int tl;
        bit ar, cv, mp;
        logic r;
        logic [31:0] v;
        @(negedge clk_in);
        tl = (m_head + m_n) % D;
        ar = rdy_in && !m_flush && (m_n < D);
        cv = rdy_in && (m_n > 0) && m_done[m_head] && (m_typ[m_head] != ROB_T_ST || st_commit_ready);
        mp = cv && (m_typ[m_head] == ROB_T_BR) && (m_val[m_head] != m_pred[m_head]);
        check("alloc_ready", alloc_ready, ar);
        check("alloc_id", alloc_id, tl);
        check("commit_valid", commit_valid, cv);
        if (cv) begin
            check("commit_id", commit_id, m_head);
            check("commit_val", commit_val, m_val[m_head]);
            check("commit_type", commit_type, m_typ[m_head]);
            check("commit_rd", commit_rd, m_rd[m_head]);
        end
        check("count", count, m_n);
        check("full", full, m_n == D);
        check("empty", empty, m_n == 0);
        check("flush_out", flush_out, m_flush);
        check("flush_pc", flush_pc, m_fpc);
        model_query(int'(q1_id), r, v);
        check("q1_ready", q1_ready, r);
        check("q1_val", q1_val, v);
        model_query(int'(q2_id), r, v);
        check("q2_ready", q2_ready, r);
        check("q2_val", q2_val, v);
        if (mp) begin
            m_fpc = m_val[m_head];
            for (int i = 0; i < D; i++) begin m_busy[i] = 0; m_done[i] = 0; end
            m_head = 0; m_n = 0;
        end else if (rdy_in) begin
            for (int k = 0; k < WP; k++) begin
                int wid;
                wid = int'(wb_id[k*SB +: SB]);
                if (wb_valid[k] && m_busy[wid] && !m_flush) begin
                    m_done[wid] = 1;
                    m_val[wid]  = wb_val[k*32 +: 32];
                end
            end
            if (cv) begin
                m_busy[m_head] = 0;
                m_head = (m_head + 1) % D;
                m_n--;
            end
            if (ar && alloc_valid) begin
                m_busy[tl] = 1; m_done[tl] = alloc_done; m_typ[tl] = alloc_type;
                m_rd[tl] = alloc_rd; m_val[tl] = alloc_val; m_pred[tl] = alloc_pred_pc;
                m_n++;
            end
        end
        m_flush = mp;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 0;
        set_idle();
        #1;
        model_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_alloc_id", alloc_id, 0);
        check("rst_flush_out", flush_out, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_q1_ready", q1_ready, 0);
        check("rst_q1_val", q1_val, 0);
        @(posedge clk_in);
        #1;
        rst_in = 1;
    endtask

    initial begin
        set_idle();
        rdy_in = 1;
        do_reset();

        // Three pending Rd entries, then out-of-order writeback.
        for (int i = 0; i < 3; i++) begin
            set_alloc(ROB_T_RD, 5'(i + 1), 1'b0, 32'd0, 32'd0);
            #1;
            check("alloc_id_seq", alloc_id, i);
            cycle();
        end
        set_idle();
        #1;
        check("count3", count, 3);
        check("empty3", empty, 0);
        set_wb(0, 1, 32'h55);
        #1;
        check("no_commit_id1", commit_valid, 0);
        cycle();
        set_idle();
        set_wb(1, 0, 32'h11);
        cycle();
        set_idle();
        #1;
        check("commit0_valid", commit_valid, 1);
        check("commit0_id", commit_id, 0);
        check("commit0_val", commit_val, 32'h11);
        cycle();
        #1;
        check("commit1_id", commit_id, 1);
        check("commit1_val", commit_val, 32'h55);
        cycle();

        // Both ports hit id2 in one cycle; port 1 must win.
        set_wb(0, 2, 32'hA);
        set_wb(1, 2, 32'hB);
        q1_id = SB'(2);
        #1;
`ifdef ROB_WB_BYPASS_EN
        check("bypass_q1_ready", q1_ready, 1);
        check("bypass_q1_val", q1_val, 32'hB);
`else
        check("nobypass_q1_ready", q1_ready, 0);
`endif
        cycle();
        set_idle();
        q1_id = SB'(2);
        #1;
        check("dual_wb_val", q1_val, 32'hB);
        check("dual_wb_commit", commit_val, 32'hB);
        cycle();

        // Mid-operation reset, then fill and wrap.
        set_alloc(ROB_T_RD, 5'd3, 1'b1, 32'h9, 32'd0);
        cycle();
        do_reset();
        for (int i = 0; i < D; i++) begin
            set_alloc(ROB_T_OTHER, 5'(i), 1'b0, 32'(i), 32'd0);
            cycle();
        end
        #1;
        check("fill_full", full, 1);
        check("fill_alloc_ready", alloc_ready, 0);
        set_wb(1, 0, 32'h77);
        cycle();
        wb_valid = '0;
        #1;
        check("wrap_commit", commit_valid, 1);
        check("wrap_ready_blocked", alloc_ready, 0);
        cycle();
        #1;
        check("wrap_ready", alloc_ready, 1);
        check("wrap_tail0", alloc_id, 0);
        cycle();
        #1;
        check("wrap_full_again", full, 1);
        check("wrap_tail1", alloc_id, 1);
        cycle();

        // Branch mispredict at head.
        do_reset();
        set_alloc(ROB_T_BR, 5'd0, 1'b0, 32'd0, 32'h100);
        cycle();
        set_idle();
        set_wb(0, 0, 32'h200);
        cycle();
        set_idle();
        set_alloc(ROB_T_RD, 5'd7, 1'b1, 32'h33, 32'd0);
        #1;
        check("br_commit", commit_valid, 1);
        cycle();
        #1;
        check("br_flush_out", flush_out, 1);
        check("br_flush_pc", flush_pc, 32'h200);
        check("br_count", count, 0);
        check("br_alloc_blocked", alloc_ready, 0);
        cycle();
        #1;
        check("br_flush_done", flush_out, 0);
        check("br_dropped", count, 0);
        check("br_resume", alloc_ready, 1);
        cycle();
        set_idle();
        #1;
        check("br_alloc_after", count, 1);
        cycle();

        // Store held at head until the LSB accepts it.
        do_reset();
        set_alloc(ROB_T_ST, 5'd0, 1'b1, 32'h44, 32'd0);
        st_commit_ready = 0;
        cycle();
        alloc_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("st_stall", commit_valid, 0);
            cycle();
        end
        st_commit_ready = 1;
        #1;
        check("st_go", commit_valid, 1);
        check("st_type", commit_type, ROB_T_ST);
        cycle();
        #1;
        check("st_empty", empty, 1);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            rdy_in          = ($urandom_range(9) != 0);
            alloc_valid     = ($urandom_range(2) != 0);
            alloc_type      = 2'($urandom_range(3));
            alloc_rd        = 5'($urandom);
            alloc_done      = ($urandom_range(3) == 0);
            alloc_val       = $urandom;
            alloc_pc        = $urandom;
            alloc_pred_pc   = ($urandom_range(1) != 0) ? 32'h100 : 32'h104;
            for (int k = 0; k < WP; k++) begin
                wb_valid[k]        = ($urandom_range(1) != 0);
                wb_id[k*SB +: SB]  = SB'($urandom_range(D - 1));
                wb_val[k*32 +: 32] = ($urandom_range(1) != 0)
                                     ? (($urandom_range(1) != 0) ? 32'h100 : 32'h104) : $urandom;
            end
            st_commit_ready = ($urandom_range(2) != 0);
            q1_id           = SB'($urandom_range(D - 1));
            q2_id           = SB'($urandom_range(D - 1));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
